// File: rtl/l1_cache_pkg.sv
// Shared types and address-field helpers for the L1 data cache.
// Widths are derived from the cache geometry at elaboration time.
package l1_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE,
    REFILL
  } state_e;

  typedef logic [63:0] field_t;

  function automatic int offset_w(int data_w);
    return $clog2(data_w / 8);
  endfunction

  function automatic int word_w(int line_words);
    return $clog2(line_words);
  endfunction

  function automatic int index_w(int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(int addr_w, int data_w,
                               int line_words, int sets);
    return addr_w - offset_w(data_w)
         - word_w(line_words) - index_w(sets);
  endfunction

  function automatic field_t bits(field_t a, int lsb, int w);
    return (a >> lsb) & ((field_t'(1) << w) - field_t'(1));
  endfunction

  function automatic field_t get_word(field_t a, int data_w,
                                      int line_words);
    return bits(a, offset_w(data_w), word_w(line_words));
  endfunction

  function automatic field_t get_index(field_t a, int data_w,
                                       int line_words, int sets);
    return bits(a, offset_w(data_w) + word_w(line_words),
                index_w(sets));
  endfunction

  function automatic field_t get_tag(field_t a, int addr_w,
                                     int data_w, int line_words,
                                     int sets);
    int lsb;
    lsb = offset_w(data_w) + word_w(line_words) + index_w(sets);
    return bits(a, lsb, addr_w - lsb);
  endfunction

endpackage

// File: rtl/l1_cache_way.sv
// One cache way: tag/valid/dirty/data arrays, async read,
// byte-enabled word store and whole-line fill.
module l1_cache_way
  import l1_cache_pkg::*;
#(
  parameter int TAG_W      = 22,
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 4,
  parameter int DATA_W     = 32,
  localparam int INDEX_W   = index_w(SETS),
  localparam int WORD_W    = word_w(LINE_WORDS),
  localparam int LINE_W    = DATA_W * LINE_WORDS,
  localparam int BE_W      = DATA_W / 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [INDEX_W-1:0] index_i,
  output logic [TAG_W-1:0]   tag_o,
  output logic               valid_o,
  output logic               dirty_o,
  output logic [LINE_W-1:0]  line_o,
  input  logic               wr_en_i,
  input  logic [WORD_W-1:0]  word_i,
  input  logic [DATA_W-1:0]  wdata_i,
  input  logic [BE_W-1:0]    be_i,
  input  logic               fill_en_i,
  input  logic [TAG_W-1:0]   fill_tag_i,
  input  logic [LINE_W-1:0]  fill_line_i
);

  logic [TAG_W-1:0]  tag_q  [SETS];
  logic [LINE_W-1:0] data_q [SETS];
  logic [SETS-1:0]   valid_q;
  logic [SETS-1:0]   dirty_q;

  assign tag_o   = tag_q[index_i];
  assign line_o  = data_q[index_i];
  assign valid_o = valid_q[index_i];
  assign dirty_o = dirty_q[index_i];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_en_i) begin
      valid_q[index_i] <= 1'b1;
      dirty_q[index_i] <= 1'b0;
    end else if (wr_en_i) begin
      dirty_q[index_i] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; valid bits gate them.
  always_ff @(posedge clk_i) begin
    if (fill_en_i) begin
      tag_q[index_i]  <= fill_tag_i;
      data_q[index_i] <= fill_line_i;
    end else if (wr_en_i) begin
      for (int b = 0; b < BE_W; b++) begin
        if (be_i[b])
          data_q[index_i][int'(word_i)*DATA_W + b*8 +: 8]
            <= wdata_i[b*8 +: 8];
      end
    end
  end

endmodule

// File: rtl/l1_dcache_ctrl.sv
// Set-associative write-back, write-allocate L1 data cache
// controller with true-LRU replacement.
module l1_dcache_ctrl
  import l1_cache_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int LINE_WORDS = 4,
  parameter int SETS       = 64,
  parameter int WAYS       = 2,
  localparam int LINE_W    = DATA_W * LINE_WORDS
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [ADDR_W-1:0]   cpu_addr_i,
  input  logic [DATA_W-1:0]   cpu_wdata_i,
  input  logic [DATA_W/8-1:0] cpu_be_i,
  input  logic                cpu_read_i,
  input  logic                cpu_write_i,
  output logic [DATA_W-1:0]   cpu_rdata_o,
  output logic                cpu_stall_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [LINE_W-1:0]   mem_wdata_o,
  output logic                mem_enable_o,
  output logic                mem_write_o,
  input  logic [LINE_W-1:0]   mem_rdata_i,
  input  logic                mem_ack_i
);

  localparam int OFFSET_W = offset_w(DATA_W);
  localparam int WORD_W   = word_w(LINE_WORDS);
  localparam int INDEX_W  = index_w(SETS);
  localparam int TAG_W    = tag_w(ADDR_W, DATA_W, LINE_WORDS, SETS);
  localparam int LOW_W    = OFFSET_W + WORD_W;
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [WORD_W-1:0]  req_word;

  assign req_tag  = TAG_W'(get_tag(field_t'(cpu_addr_i),
                    ADDR_W, DATA_W, LINE_WORDS, SETS));
  assign req_idx  = INDEX_W'(get_index(field_t'(cpu_addr_i),
                    DATA_W, LINE_WORDS, SETS));
  assign req_word = WORD_W'(get_word(field_t'(cpu_addr_i),
                    DATA_W, LINE_WORDS));

  state_e state_q, state_d;

  logic [TAG_W-1:0]  way_tag  [WAYS];
  logic [LINE_W-1:0] way_line [WAYS];
  logic [WAYS-1:0]   way_valid, way_dirty;
  logic [WAYS-1:0]   hit_vec, wr_en, fill_en;

  logic [WAY_W-1:0]  hit_way, lru_way, victim_d, victim_q;
  logic [WAY_W-1:0]  touch_way;
  logic [LINE_W-1:0] hit_line;
  logic              req, hit, miss, touch;

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    l1_cache_way #(
      .TAG_W      (TAG_W),
      .SETS       (SETS),
      .LINE_WORDS (LINE_WORDS),
      .DATA_W     (DATA_W)
    ) u_way (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .index_i     (req_idx),
      .tag_o       (way_tag[w]),
      .valid_o     (way_valid[w]),
      .dirty_o     (way_dirty[w]),
      .line_o      (way_line[w]),
      .wr_en_i     (wr_en[w]),
      .word_i      (req_word),
      .wdata_i     (cpu_wdata_i),
      .be_i        (cpu_be_i),
      .fill_en_i   (fill_en[w]),
      .fill_tag_i  (req_tag),
      .fill_line_i (mem_rdata_i)
    );
  end

  always_comb begin
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = way_valid[w] && (way_tag[w] == req_tag);
      wr_en[w]   = (state_q == IDLE) && cpu_write_i
                && hit_vec[w];
      fill_en[w] = (state_q == ALLOCATE) && mem_ack_i
                && (victim_q == WAY_W'(w));
      if (hit_vec[w])
        hit_way = WAY_W'(w);
    end
  end

  assign req      = cpu_read_i | cpu_write_i;
  assign hit      = |hit_vec;
  assign miss     = req & ~hit;
  assign hit_line = way_line[hit_way];

  assign cpu_rdata_o = hit
    ? hit_line[int'(req_word)*DATA_W +: DATA_W]
    : '0;

  assign touch = ((state_q == IDLE) && req && hit)
              || ((state_q == ALLOCATE) && mem_ack_i);
  assign touch_way = (state_q == ALLOCATE) ? victim_q : hit_way;

  if (WAYS == 1) begin : g_lru1
    assign lru_way = '0;
  end else if (WAYS == 2) begin : g_lru2
    // Bit holds the least-recently-used way of the set.
    logic [SETS-1:0] lru_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
        lru_q <= '0;
      else if (touch)
        lru_q[req_idx] <= ~touch_way[0];
    end
    assign lru_way = lru_q[req_idx];
  end else begin : g_lru_age
    logic [WAY_W-1:0] age_q [SETS][WAYS];
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        for (int s = 0; s < SETS; s++)
          for (int w = 0; w < WAYS; w++)
            age_q[s][w] <= WAY_W'(w);
      end else if (touch) begin
        for (int w = 0; w < WAYS; w++) begin
          if (WAY_W'(w) == touch_way)
            age_q[req_idx][w] <= '0;
          else if (age_q[req_idx][w]
                   < age_q[req_idx][touch_way])
            age_q[req_idx][w] <= age_q[req_idx][w] + 1'b1;
        end
      end
    end
    always_comb begin
      lru_way = '0;
      for (int w = 0; w < WAYS; w++)
        if (age_q[req_idx][w] == WAY_W'(WAYS - 1))
          lru_way = WAY_W'(w);
    end
  end

  // Lowest invalid way wins over the LRU way.
  always_comb begin
    victim_d = lru_way;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!way_valid[w])
        victim_d = WAY_W'(w);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      victim_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE)
        victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:
        if (miss)
          state_d = way_dirty[victim_d] ? WRITEBACK : ALLOCATE;
      WRITEBACK:
        if (mem_ack_i)
          state_d = ALLOCATE;
      ALLOCATE:
        if (mem_ack_i)
          state_d = REFILL;
      REFILL:
        state_d = IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_wdata_o  = '0;
    cpu_stall_o  = 1'b0;
    unique case (state_q)
      IDLE:
        cpu_stall_o = miss;
      WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {way_tag[victim_q], req_idx,
                        {LOW_W{1'b0}}};
        mem_wdata_o  = way_line[victim_q];
        cpu_stall_o  = 1'b1;
      end
      ALLOCATE: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, req_idx, {LOW_W{1'b0}}};
        cpu_stall_o  = 1'b1;
      end
      REFILL:
        cpu_stall_o = 1'b1;
      default: ;
    endcase
    if (rst_i)
      cpu_stall_o = 1'b0;
  end

endmodule

// File: tb/tb_l1_dcache_ctrl.sv
// Bench for l1_dcache_ctrl: a 2-way and a direct-mapped instance
// run the same accesses against an LRU-list cache model.
module tb_l1_dcache_ctrl;

  typedef struct packed {
    logic         wr;
    logic [31:0]  addr;
    logic [127:0] data;
  } txn_t;

  logic        clk, rst;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [3:0]  cpu_be;
  logic        cpu_read, cpu_write;
  logic        late_ack;

  logic [31:0]  rdata     [2];
  logic         stall     [2];
  logic [31:0]  mem_addr  [2];
  logic [127:0] mem_wdata [2];
  logic         mem_en    [2];
  logic         mem_wr    [2];
  logic [127:0] mem_rdata [2];
  logic         mem_ack   [2];

  int n_assert = 0;
  int n_fail   = 0;

  txn_t act0[$], act1[$], exp0[$], exp1[$];

  logic [127:0] mem_bk [logic [63:0]];
  logic [127:0] m_mem  [logic [63:0]];
  logic [31:0]  m_line  [2][64][2];
  logic [127:0] m_data  [2][64][2];
  bit           m_dirty [2][64][2];
  int           m_cnt   [2][64];

  l1_dcache_ctrl #(.WAYS(2)) u_dut0 (
    .clk_i(clk), .rst_i(rst),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_be_i(cpu_be), .cpu_read_i(cpu_read),
    .cpu_write_i(cpu_write), .cpu_rdata_o(rdata[0]),
    .cpu_stall_o(stall[0]), .mem_addr_o(mem_addr[0]),
    .mem_wdata_o(mem_wdata[0]), .mem_enable_o(mem_en[0]),
    .mem_write_o(mem_wr[0]), .mem_rdata_i(mem_rdata[0]),
    .mem_ack_i(mem_ack[0])
  );

  l1_dcache_ctrl #(.WAYS(1)) u_dut1 (
    .clk_i(clk), .rst_i(rst),
    .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_be_i(cpu_be), .cpu_read_i(cpu_read),
    .cpu_write_i(cpu_write), .cpu_rdata_o(rdata[1]),
    .cpu_stall_o(stall[1]), .mem_addr_o(mem_addr[1]),
    .mem_wdata_o(mem_wdata[1]), .mem_enable_o(mem_en[1]),
    .mem_write_o(mem_wr[1]), .mem_rdata_i(mem_rdata[1]),
    .mem_ack_i(mem_ack[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] key(int d, logic [31:0] a);
    return {d[31:0], a};
  endfunction

  function automatic logic [127:0] init_line(logic [31:0] a);
    logic [127:0] r;
    for (int i = 0; i < 4; i++)
      r[i*32 +: 32] = (a + 32'(i*4)) ^ 32'h5EED_0000;
    return r;
  endfunction

  function automatic logic [127:0] fetch_bk(int d, logic [31:0] a);
    if (mem_bk.exists(key(d, a))) return mem_bk[key(d, a)];
    return init_line(a);
  endfunction

  function automatic logic [127:0] fetch_m(int d, logic [31:0] a);
    if (m_mem.exists(key(d, a))) return m_mem[key(d, a)];
    return init_line(a);
  endfunction

  // Memory: acks on the third cycle of each request.
  for (genvar g = 0; g < 2; g++) begin : g_mem
    int   cnt;
    txn_t t;
    initial begin
      mem_ack[g]   = 1'b0;
      mem_rdata[g] = '0;
      cnt = 0;
      forever begin
        @(negedge clk);
        if (mem_ack[g]) begin
          mem_ack[g] = 1'b0;
          cnt = 0;
        end
        if (!mem_en[g]) begin
          cnt = 0;
        end else begin
          cnt++;
          if (cnt == 3) begin
            t.wr   = mem_wr[g];
            t.addr = mem_addr[g];
            t.data = mem_wr[g] ? mem_wdata[g] : '0;
            if (mem_wr[g])
              mem_bk[key(g, mem_addr[g])] = mem_wdata[g];
            else
              mem_rdata[g] = fetch_bk(g, mem_addr[g]);
            if (g == 0) act0.push_back(t);
            else act1.push_back(t);
            mem_ack[g] = 1'b1;
          end
        end
        if (late_ack) mem_ack[g] = 1'b1;
      end
    end
  end

  task automatic check(input string nm, input logic [127:0] obs,
                       input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", nm, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++)
      for (int s = 0; s < 64; s++)
        m_cnt[d][s] = 0;
  endtask

  // Each set is an MRU-first list; the tail is the LRU line.
  task automatic model_access(input int d, input logic [31:0] a,
                              input bit wr, input logic [31:0] wd,
                              input logic [3:0] be,
                              output logic [31:0] rd,
                              output int stall_cyc);
    int ways, set, wi, pos, v;
    logic [31:0]  line, tl;
    logic [127:0] ln;
    bit           td;
    txn_t         t;
    ways = (d == 0) ? 2 : 1;
    line = a & 32'hFFFF_FFF0;
    set  = int'(a[9:4]);
    wi   = int'(a[3:2]);
    pos  = -1;
    for (int i = 0; i < m_cnt[d][set]; i++)
      if (m_line[d][set][i] == line) pos = i;
    if (pos < 0) begin
      stall_cyc = 5;
      if (m_cnt[d][set] == ways) begin
        v = ways - 1;
        if (m_dirty[d][set][v]) begin
          t = '{1'b1, m_line[d][set][v], m_data[d][set][v]};
          if (d == 0) exp0.push_back(t); else exp1.push_back(t);
          m_mem[key(d, m_line[d][set][v])] = m_data[d][set][v];
          stall_cyc = 8;
        end
        m_cnt[d][set]--;
      end
      t = '{1'b0, line, 128'b0};
      if (d == 0) exp0.push_back(t); else exp1.push_back(t);
      for (int i = m_cnt[d][set]; i > 0; i--) begin
        m_line[d][set][i]  = m_line[d][set][i-1];
        m_data[d][set][i]  = m_data[d][set][i-1];
        m_dirty[d][set][i] = m_dirty[d][set][i-1];
      end
      m_line[d][set][0]  = line;
      m_data[d][set][0]  = fetch_m(d, line);
      m_dirty[d][set][0] = 1'b0;
      m_cnt[d][set]++;
    end else begin
      stall_cyc = 0;
      tl = m_line[d][set][pos];
      ln = m_data[d][set][pos];
      td = m_dirty[d][set][pos];
      for (int i = pos; i > 0; i--) begin
        m_line[d][set][i]  = m_line[d][set][i-1];
        m_data[d][set][i]  = m_data[d][set][i-1];
        m_dirty[d][set][i] = m_dirty[d][set][i-1];
      end
      m_line[d][set][0]  = tl;
      m_data[d][set][0]  = ln;
      m_dirty[d][set][0] = td;
    end
    ln = m_data[d][set][0];
    rd = ln[wi*32 +: 32];
    if (wr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) ln[wi*32 + b*8 +: 8] = wd[b*8 +: 8];
      m_data[d][set][0]  = ln;
      m_dirty[d][set][0] = 1'b1;
    end
  endtask

  task automatic cmp_q(input string nm, input txn_t a[$],
                       input txn_t e[$]);
    int n;
    check({nm, "_count"}, 128'(a.size()), 128'(e.size()));
    n = (a.size() < e.size()) ? a.size() : e.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s%0d_wr", nm, i), 128'(a[i].wr),
            128'(e[i].wr));
      check($sformatf("%s%0d_addr", nm, i), 128'(a[i].addr),
            128'(e[i].addr));
      if (e[i].wr)
        check($sformatf("%s%0d_data", nm, i), a[i].data,
              e[i].data);
    end
  endtask

  task automatic access(input logic [31:0] a, input bit rd,
                        input bit wr, input logic [31:0] wd,
                        input logic [3:0] be, input string nm);
    logic [31:0] er [2];
    int es [2];
    int sc [2];
    int cyc;
    for (int d = 0; d < 2; d++) begin
      model_access(d, a, wr, wd, be, er[d], es[d]);
      sc[d] = 0;
    end
    cpu_addr  = a;
    cpu_wdata = wd;
    cpu_be    = be;
    cpu_read  = rd;
    cpu_write = wr;
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      for (int d = 0; d < 2; d++) sc[d] += int'(stall[d]);
      if (!stall[0] && !stall[1]) break;
      if (cyc > 200) break;
    end
    n_assert++;
    assert (cyc <= 200) else begin
      n_fail++;
      $error("FAIL %s_timeout: observed %0d cycles required <= 200",
             nm, cyc);
    end
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_stall%0d", nm, d), 128'(sc[d]),
            128'(es[d]));
      if (rd && !wr)
        check($sformatf("%s_rdata%0d", nm, d), 128'(rdata[d]),
              128'(er[d]));
    end
    @(posedge clk);
    #1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cmp_q({nm, "_mem0_"}, act0, exp0);
    cmp_q({nm, "_mem1_"}, act1, exp1);
    act0.delete(); act1.delete();
    exp0.delete(); exp1.delete();
  endtask

  task automatic check_idle_outputs(input string nm);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_en%0d", nm, d), 128'(mem_en[d]), 0);
      check($sformatf("%s_wr%0d", nm, d), 128'(mem_wr[d]), 0);
      check($sformatf("%s_addr%0d", nm, d), 128'(mem_addr[d]), 0);
      check($sformatf("%s_wdata%0d", nm, d), mem_wdata[d], 0);
      check($sformatf("%s_stall%0d", nm, d), 128'(stall[d]), 0);
      check($sformatf("%s_rdata%0d", nm, d), 128'(rdata[d]), 0);
    end
  endtask

  initial begin
    int cyc;
    logic [31:0] a, wd;
    logic [3:0]  be;
    int op;
    rst = 1'b1;
    late_ack  = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    cpu_be    = '0;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    for (int d = 0; d < 2; d++) begin
      mem_bk[key(d, 32'h100)] = {32'h44, 32'h33, 32'h22, 32'h11};
      m_mem[key(d, 32'h100)]  = {32'h44, 32'h33, 32'h22, 32'h11};
    end
    model_reset();
    @(negedge clk);
    check_idle_outputs("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;

    access(32'h100, 1, 0, 0, 0, "cold_rd");
    access(32'h104, 1, 0, 0, 0, "hit_rd");
    access(32'h100, 0, 1, 32'hAABBCCDD, 4'b0010, "st_hit");
    access(32'h100, 1, 0, 0, 0, "rd_merged");
    access(32'h500, 1, 0, 0, 0, "rd_way1");
    access(32'h900, 1, 0, 0, 0, "rd_evict");
    access(32'h500, 1, 0, 0, 0, "rd_lru_hit");
    access(32'h100, 1, 0, 0, 0, "rd_refetch");

    cpu_addr = 32'h200;
    cpu_read = 1'b1;
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!mem_en[0] && cyc < 20);
    n_assert++;
    assert (mem_en[0] === 1'b1) else begin
      n_fail++;
      $error("FAIL alloc_wait: observed %0b required 1", mem_en[0]);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_idle_outputs("mid_rst");
    model_reset();
    cpu_read = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    late_ack = 1'b1;
    @(posedge clk);
    #1;
    late_ack = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("late_ack_stall%0d", d), 128'(stall[d]), 0);
      check($sformatf("late_ack_en%0d", d), 128'(mem_en[d]), 0);
    end
    check("late_ack_txn", 128'(act0.size() + act1.size()), 0);
    act0.delete(); act1.delete();
    exp0.delete(); exp1.delete();
    @(posedge clk);
    #1;

    access(32'h200, 1, 0, 0, 0, "rd_after_rst");
    access(32'h300, 0, 1, 32'hDEADBEEF, 4'hF, "st_miss");
    access(32'h300, 1, 0, 0, 0, "rd_st_miss");
    access(32'h700, 1, 0, 0, 0, "rd_conflict");
    access(32'hB00, 1, 0, 0, 0, "rd_evict_st");
    access(32'hC04, 0, 1, 32'h12345678, 4'h0, "st_be0");

    for (int n = 0; n < 80; n++) begin
      a  = (32'($urandom_range(0, 3)) << 10)
         | (32'($urandom_range(0, 2)) << 4)
         | (32'($urandom_range(0, 3)) << 2);
      wd = $urandom;
      be = 4'($urandom);
      op = $urandom_range(0, 3);
      access(a, op != 2, op >= 2, wd, be, $sformatf("rnd%0d", n));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/l1_dcache_ctrl.md
Name: l1_dcache_ctrl

Overview:
- Parametrised, set-associative, write-back, write-allocate L1 data cache controller.
- Sits between the pipeline MEM stage (word/byte accesses, stall output) and a line-wide main-memory port with a req/ack handshake.
- Generalises the fixed direct-mapped controller: configurable sets, ways and line size, per-byte write enables, and true-LRU replacement.

Parameters:
ADDR_W, 32, byte address width
DATA_W, 32, CPU word width; power of two, at least 8
LINE_WORDS, 4, words per line; power of two
SETS, 64, number of sets; power of two
WAYS, 2, associativity, 1 to 4; WAYS=1 gives direct-mapped
LINE_W, DATA_W*LINE_WORDS, memory port width (derived, not overridable)

Ports:
clk_i  in  1  clock
rst_i  in  1  reset; active-high, asynchronous
cpu_addr_i  in  ADDR_W  byte address of access
cpu_wdata_i  in  DATA_W  store data, already lane-aligned
cpu_be_i  in  DATA_W/8  byte enables for stores
cpu_read_i  in  1  load request
cpu_write_i  in  1  store request
cpu_rdata_o  out  DATA_W  load data (full word)
cpu_stall_o  out  1  freeze pipeline
mem_addr_o  out  ADDR_W  line-aligned memory address
mem_wdata_o  out  LINE_W  writeback line
mem_enable_o  out  1  memory request; held until ack
mem_write_o  out  1  1 = writeback, 0 = refill
mem_rdata_i  in  LINE_W  refill line
mem_ack_i  in  1  one-cycle completion pulse

Behaviour:
- Address split: offset = low log2(DATA_W/8) bits, ignored. Then word index log2(LINE_WORDS), then set index log2(SETS), then tag in the remaining upper bits.
- Reset (async, rst_i=1):
  - All valid, dirty and LRU bits are cleared; FSM goes to IDLE.
  - Outputs: mem_enable_o=0, mem_write_o=0, cpu_stall_o=0, mem_addr_o=0, mem_wdata_o=0, cpu_rdata_o=0.
  - Dirty data is discarded. Reset mid-transaction abandons it; a late mem_ack_i is ignored.
- Hit (IDLE, valid && tag match in some way):
  - Zero-latency. cpu_stall_o=0 combinationally.
  - Load: cpu_rdata_o carries the selected word in the same cycle.
  - Store: bytes with cpu_be_i=1 are written at the clock edge; that line's dirty bit is set.
  - LRU is updated to mark the hit way most-recently-used.
- Miss: cpu_stall_o=1 combinationally in the same cycle as the request.
- Victim selection: lowest-index invalid way; otherwise the LRU way. With WAYS=1, always way 0.
- FSM states:
  - IDLE: miss with dirty victim -> WRITEBACK; miss with clean victim -> ALLOCATE; otherwise stay.
  - WRITEBACK: mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, set, 0}, mem_wdata_o=victim line. On mem_ack_i -> ALLOCATE.
  - ALLOCATE: mem_enable_o=1, mem_write_o=0, mem_addr_o=line-aligned cpu_addr_i. On mem_ack_i: capture mem_rdata_i into the victim way, tag written, valid=1, dirty=0 -> REFILL.
  - REFILL: one cycle, stall still 1 -> IDLE, where the access re-evaluates as a hit (store merges and sets dirty then).
- cpu_stall_o=1 in every non-IDLE state.
- Miss latency with a clean victim: mem latency + 2 cycles of stall.
- Request inputs must be held stable while cpu_stall_o=1. The controller does not re-latch them.
- Simultaneous cpu_read_i and cpu_write_i: treated as a store; the load data is still driven.
- cpu_be_i=0 with cpu_write_i=1: still allocates on miss; no byte changes; dirty bit is set.
- mem_ack_i in IDLE or REFILL is ignored. mem_enable_o never drops before ack.
- LRU encoding:
  - WAYS=2: one bit per set.
  - WAYS=3 or 4: per-set age counters of log2(WAYS) bits, reset to way index; the hit/fill way gets age 0 and younger ways are incremented.

Decomposition:
- Shared package l1_cache_pkg:
  - FSM state enum {IDLE, WRITEBACK, ALLOCATE, REFILL}.
  - Widths derived via clog2: OFFSET_W, WORD_W, INDEX_W, TAG_W.
  - Field-extract functions for tag, index and word.
- One sub-module, l1_cache_way: per-way tag/valid/dirty/data arrays with a combinational read, byte-enabled word write, and full-line fill port. It is instantiated WAYS times.
- LRU logic and the FSM stay in the top level.

Test Plan:
Config for all scenarios: SETS=64, LINE_WORDS=4, WAYS=2, memory acks 3 cycles after mem_enable_o rises.
- Cold read 0x100 -> mem_enable_o=1, mem_write_o=0, mem_addr_o=0x100. Return line {0x44,0x33,0x22,0x11} (word0=0x11) -> stall for 5 cycles, then cpu_rdata_o=0x11. Next read 0x104 -> stall=0, data=0x22.
- Store 0x100, be=4'b0010, wdata=0xAABBCCDD on a hit -> no mem request; a subsequent read gives 0x0000CC11.
- After the store, read 0x500 (same set) -> fills way 1, no writeback. Then read 0x900 -> WRITEBACK with addr 0x100, word0=0x0000CC11, then ALLOCATE 0x900. A final read 0x500 hits.
- Assert rst_i during ALLOCATE for read 0x200 -> outputs go to 0 immediately; a late ack is ignored. Re-read 0x200 -> misses again.
- Store miss 0x300, be=4'hF, data=0xDEADBEEF -> refill, then merge. Evicting the line later writes back 0xDEADBEEF.
- WAYS=1: read 0x100, then 0x500 -> the second access evicts the first; read 0x100 again -> miss.
